// File: rtl/stopwatch_mode_seq_if.sv
// Signal bundle between the button front end / mode switch and the stopwatch
// mode controller, plus the controller's registered control outputs.
interface stopwatch_mode_seq_if;
  // Protocol: tick, start_pulse, lap_pulse, clear and set_*_inc are single-cycle
  // strobes sampled on the rising clock edge; there is no backpressure, so every
  // strobe is consumed in the cycle it is seen. Levels (lap_level, mode_set,
  // count_en, lap_hold, blink, state) are valid every cycle.
  logic       tick;
  logic       start_pulse;
  logic       lap_pulse;
  logic       lap_level;
  logic       mode_set;
  logic       count_en;
  logic       clear;
  logic       lap_hold;
  logic       set_hour_inc;
  logic       set_min_inc;
  logic       blink;
  logic [2:0] state;

  modport master (
    output tick, start_pulse, lap_pulse, lap_level, mode_set,
    input  count_en, clear, lap_hold, set_hour_inc, set_min_inc, blink, state
  );

  modport slave (
    input  tick, start_pulse, lap_pulse, lap_level, mode_set,
    output count_en, clear, lap_hold, set_hour_inc, set_min_inc, blink, state
  );
endinterface

// File: rtl/stopwatch_mode_seq.sv
// Stopwatch mode controller: RUN/PAUSE/LAP/SET state machine with long-press
// clear in PAUSE and a blink strobe in time-set mode. All outputs registered.
module stopwatch_mode_seq #(
  parameter int HOLD_TICKS  = 200,
  parameter int BLINK_TICKS = 50,
  parameter int CW          = 8
) (
  input logic             clk,
  input logic             rst_n,
  stopwatch_mode_seq_if.slave sw
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_PAUSE     = 3'd2,
    S_LAP       = 3'd3,
    S_LAP_PAUSE = 3'd4,
    S_SET       = 3'd5
  } state_e;

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_TICKS - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            hold_block_q, hold_block_d;
  logic            blink_q, blink_d;
  logic            count_en_q, count_en_d;
  logic            clear_q, clear_d;
  logic            lap_hold_q, lap_hold_d;
  logic            hour_inc_q, hour_inc_d;
  logic            min_inc_q, min_inc_d;
  logic            hold_expire;
  logic            hold_fired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hold_cnt_q   <= '0;
      blink_cnt_q  <= '0;
      hold_block_q <= 1'b0;
      blink_q      <= 1'b0;
      count_en_q   <= 1'b0;
      clear_q      <= 1'b0;
      lap_hold_q   <= 1'b0;
      hour_inc_q   <= 1'b0;
      min_inc_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      hold_block_q <= hold_block_d;
      blink_q      <= blink_d;
      count_en_q   <= count_en_d;
      clear_q      <= clear_d;
      lap_hold_q   <= lap_hold_d;
      hour_inc_q   <= hour_inc_d;
      min_inc_q    <= min_inc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_d     = 1'b0;
    hour_inc_d  = 1'b0;
    min_inc_d   = 1'b0;
    hold_fired  = 1'b0;
    hold_expire = (state_q == S_PAUSE) && sw.lap_level && !hold_block_q &&
                  sw.tick && (hold_cnt_q == HOLD_LAST);

    case (state_q)
      S_SET: begin
        // Leaving SET is handled before the buttons so clear and inc never coincide.
        if (!sw.mode_set) begin
          state_d = S_IDLE;
          clear_d = 1'b1;
        end else if (sw.start_pulse) begin
          hour_inc_d = 1'b1;
        end else if (sw.lap_pulse) begin
          min_inc_d = 1'b1;
        end
      end
      S_IDLE, S_RUN, S_PAUSE, S_LAP, S_LAP_PAUSE: begin
        if (sw.mode_set) begin
          state_d = S_SET;
        end else if (sw.start_pulse) begin
          case (state_q)
            S_IDLE:      state_d = S_RUN;
            S_RUN:       state_d = S_PAUSE;
            S_PAUSE:     state_d = S_RUN;
            S_LAP:       state_d = S_LAP_PAUSE;
            S_LAP_PAUSE: state_d = S_LAP;
            default:     state_d = state_q;
          endcase
        end else if (sw.lap_pulse) begin
          case (state_q)
            S_RUN:       state_d = S_LAP;
            S_LAP:       state_d = S_RUN;
            S_LAP_PAUSE: state_d = S_PAUSE;
            default:     state_d = state_q;
          endcase
        end else if (hold_expire) begin
          state_d    = S_IDLE;
          clear_d    = 1'b1;
          hold_fired = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Once a long press has cleared, the button must be released before it can arm again.
    hold_block_d = (hold_block_q && sw.lap_level) || hold_fired;

    hold_cnt_d = '0;
    if ((state_q == S_PAUSE) && (state_d == S_PAUSE) && sw.lap_level && !hold_block_q) begin
      hold_cnt_d = sw.tick ? hold_cnt_q + 1'b1 : hold_cnt_q;
    end

    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if ((state_q == S_SET) && (state_d == S_SET)) begin
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;
      if (sw.tick) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          blink_d     = !blink_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    end

    count_en_d = (state_d == S_RUN) || (state_d == S_LAP);
    lap_hold_d = (state_d == S_LAP) || (state_d == S_LAP_PAUSE);
  end

  assign sw.state        = state_q;
  assign sw.count_en     = count_en_q;
  assign sw.clear        = clear_q;
  assign sw.lap_hold     = lap_hold_q;
  assign sw.set_hour_inc = hour_inc_q;
  assign sw.set_min_inc  = min_inc_q;
  assign sw.blink        = blink_q;

endmodule
